// File: rtl/uart_reg_responder_if.sv
// UART FIFO-side bundle: receive FIFO pop side and transmit FIFO push side.
// master = responder, slave = the FIFO pair.
interface uart_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, w_data, wr_uart
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, w_data, wr_uart
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Byte-command register responder: 'W' addr data / 'R' addr frames over
// a UART FIFO pair, answering 'K', the register value, or 'E'.
module uart_reg_responder #(
    parameter int NREG    = 4,
    parameter int TIMEOUT = 65535,
    parameter int TO_BIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_if.master            u,
    output logic [8*NREG-1:0] regs,
    output logic              busy,
    output logic              timeout_tick
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    localparam int              AW      = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [8:0]      NREG_W  = 9'(NREG);
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_K = 8'h4B;

    logic [2:0]        r_state;
    logic              r_op_wr;
    logic [7:0]        r_addr;
    logic [7:0]        r_wdat;
    logic [7:0]        r_resp;
    logic [TO_BIT-1:0] r_cnt;
    logic [7:0]        r_regs [NREG];

    logic          w_rx_state;
    logic          w_rd;
    logic          w_wr;
    logic          w_wait;
    logic          w_expire;
    logic          w_in_range;
    logic [AW-1:0] w_idx;

    // Handshake strobes and status flags, all decoded from the current state.
    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_ADDR)
                      || (r_state == S_DATA);
    assign w_rd       = reset && w_rx_state && !u.rx_empty;
    assign w_wr       = (r_state == S_SEND) && !u.tx_full;
    assign w_wait     = ((r_state == S_ADDR) || (r_state == S_DATA))
                      && u.rx_empty;
    assign w_expire   = w_wait && (r_cnt == TO_LAST);
    assign w_in_range = {1'b0, r_addr} < NREG_W;
    assign w_idx      = r_addr[AW-1:0];

    assign u.rd_uart    = w_rd;
    assign u.wr_uart    = w_wr;
    assign u.w_data     = w_wr ? r_resp : 8'h00;
    assign busy         = (r_state != S_IDLE);
    assign timeout_tick = w_expire;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
        assign regs[8*gi +: 8] = r_regs[gi];
    end

    // Frame parser, register file update and response sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op_wr <= 1'b0;
            r_addr  <= 8'h00;
            r_wdat  <= 8'h00;
            r_resp  <= 8'h00;
            r_cnt   <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rd) begin
                        if (u.r_data == CH_W || u.r_data == CH_R) begin
                            r_op_wr <= (u.r_data == CH_W);
                            r_cnt   <= '0;
                            r_state <= S_ADDR;
                        end else begin
                            r_resp  <= CH_E;
                            r_state <= S_SEND;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rd) begin
                        r_addr  <= u.r_data;
                        r_cnt   <= '0;
                        r_state <= r_op_wr ? S_DATA : S_EXEC;
                    end else if (w_expire) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + TO_BIT'(1);
                    end
                end
                S_DATA: begin
                    if (w_rd) begin
                        r_wdat  <= u.r_data;
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else if (w_expire) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + TO_BIT'(1);
                    end
                end
                S_EXEC: begin
                    if (!w_in_range) begin
                        r_resp <= CH_E;
                    end else if (r_op_wr) begin
                        r_regs[w_idx] <= r_wdat;
                        r_resp        <= CH_K;
                    end else begin
                        r_resp <= r_regs[w_idx];
                    end
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (!u.tx_full) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
